// File: rtl/vga_timing_gen.sv
// 640x480 @ 60 Hz VGA timing generator: pixel prescaler, line/frame counters, sync/blank decode
// and colour gating. Define VGA_RGB_PIPE_EN to register colour and sync pins one pixel late.
module vga_timing_gen #(
   parameter int CLK_DIV = 4,
   parameter int H_TOTAL = 800,
   parameter int H_SYNC  = 96,
   parameter int H_START = 144,
   parameter int H_END   = 783,
   parameter int V_TOTAL = 525,
   parameter int V_SYNC  = 2,
   parameter int V_START = 35,
   parameter int V_END   = 514
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] rgb,
   output logic [9:0]  hCount,
   output logic [9:0]  vCount,
   output logic        bright,
   output logic        hSync,
   output logic        vSync,
   output logic        pix_en,
   output logic        frame_tick,
   output logic [3:0]  vgaR,
   output logic [3:0]  vgaG,
   output logic [3:0]  vgaB
);

   localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

   localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
   localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
   localparam logic [9:0] H_FIRST = 10'(H_START);
   localparam logic [9:0] H_FINAL = 10'(H_END);
   localparam logic [9:0] V_FIRST = 10'(V_START);
   localparam logic [9:0] V_FINAL = 10'(V_END);
   localparam logic [9:0] CNT_ONE = 10'd1;

   logic [DIV_W-1:0] div_cnt;
   logic             h_wrap;
   logic             v_wrap;
   logic             h_vis;
   logic             v_vis;
   logic             h_sync_c;
   logic             v_sync_c;
   logic [3:0]       red_c;
   logic [3:0]       green_c;
   logic [3:0]       blue_c;

   // Prescaler: pix_en is decoded from the terminal count, so it is low in reset
   assign pix_en = (div_cnt == DIV_LAST);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
      end else if (pix_en) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DIV_ONE;
      end
   end

   assign h_wrap = (hCount == H_LAST);
   assign v_wrap = (vCount == V_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hCount     <= '0;
         vCount     <= '0;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= pix_en & h_wrap & v_wrap;
         if (pix_en) begin
            hCount <= h_wrap ? '0 : hCount + CNT_ONE;
            if (h_wrap) begin
               vCount <= v_wrap ? '0 : vCount + CNT_ONE;
            end
         end
      end
   end

   assign h_vis    = (hCount >= H_FIRST) && (hCount <= H_FINAL);
   assign v_vis    = (vCount >= V_FIRST) && (vCount <= V_FINAL);
   assign bright   = h_vis && v_vis;
   assign h_sync_c = ~(hCount < H_SYNC_W);
   assign v_sync_c = ~(vCount < V_SYNC_W);

   // Colour is forced to black outside the visible window whatever rgb carries
   assign red_c   = bright ? rgb[11:8] : 4'd0;
   assign green_c = bright ? rgb[7:4]  : 4'd0;
   assign blue_c  = bright ? rgb[3:0]  : 4'd0;

`ifdef VGA_RGB_PIPE_EN
   // Pins lag the counters by one pixel; colour and sync share the stage so they stay aligned
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vgaR  <= 4'd0;
         vgaG  <= 4'd0;
         vgaB  <= 4'd0;
         hSync <= 1'b1;
         vSync <= 1'b1;
      end else if (pix_en) begin
         vgaR  <= red_c;
         vgaG  <= green_c;
         vgaB  <= blue_c;
         hSync <= h_sync_c;
         vSync <= v_sync_c;
      end
   end
`else
   assign vgaR  = red_c;
   assign vgaG  = green_c;
   assign vgaB  = blue_c;
   assign hSync = h_sync_c;
   assign vSync = v_sync_c;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a full-size instance for prescaler/line checks and a
// reduced-geometry instance for frame, blanking and mid-frame reset checks.
module tb_vga_timing_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] rgb = 12'hF00;

   logic [9:0] b_h, b_v, s_h, s_v;
   logic       b_bright, b_hsync, b_vsync, b_pix_en, b_ft;
   logic       s_bright, s_hsync, s_vsync, s_pix_en, s_ft;
   logic [3:0] b_r, b_g, b_b, s_r, s_g, s_b;

   int n_checks = 0;
   int n_pass   = 0;

`ifdef VGA_RGB_PIPE_EN
   localparam logic EXP_SYNC_RST = 1'b1;
   localparam int   EXP_PT [7] = '{0, 15, 0, 0, 0, 15, 15};
   localparam logic EXP_HS_LINE1 = 1'b1;
`else
   localparam logic EXP_SYNC_RST = 1'b0;
   localparam int   EXP_PT [7] = '{0, 0, 0, 0, 15, 15, 15};
   localparam logic EXP_HS_LINE1 = 1'b0;
`endif

   // Small geometry: 16 px/line, 10 lines/frame, visible columns 4..13, lines 3..7
   localparam int PT_H [7] = '{3, 14, 4, 4, 4, 13, 5};
   localparam int PT_V [7] = '{3, 3, 2, 8, 3, 7, 3};

   vga_timing_gen u_big (
      .clk(clk), .rst(rst), .rgb(rgb),
      .hCount(b_h), .vCount(b_v), .bright(b_bright), .hSync(b_hsync), .vSync(b_vsync),
      .pix_en(b_pix_en), .frame_tick(b_ft), .vgaR(b_r), .vgaG(b_g), .vgaB(b_b)
   );

   vga_timing_gen #(
      .CLK_DIV(4), .H_TOTAL(16), .H_SYNC(2), .H_START(4), .H_END(13),
      .V_TOTAL(10), .V_SYNC(2), .V_START(3), .V_END(7)
   ) u_small (
      .clk(clk), .rst(rst), .rgb(rgb),
      .hCount(s_h), .vCount(s_v), .bright(s_bright), .hSync(s_hsync), .vSync(s_vsync),
      .pix_en(s_pix_en), .frame_tick(s_ft), .vgaR(s_r), .vgaG(s_g), .vgaB(s_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int hs_low, vs_low, pe_cnt, br_cnt, col_cnt, ft_cnt, ft_first, ft_second, vis_cnt;

      // Reset values on the full-size instance
      step(); step(); step();
      check("rst_h", b_h, 0);
      check("rst_v", b_v, 0);
      check("rst_pix_en", b_pix_en, 0);
      check("rst_frame_tick", b_ft, 0);
      check("rst_bright", b_bright, 0);
      check("rst_hsync", b_hsync, EXP_SYNC_RST);
      check("rst_vsync", b_vsync, EXP_SYNC_RST);
      check("rst_vgaR", b_r, 0);

      // Full-size: three lines after release (sample n = edges since release)
      rst = 1'b0;
      #1;
      hs_low = 0; vs_low = 0; pe_cnt = 0; br_cnt = 0; col_cnt = 0; ft_cnt = 0;
      for (int n = 0; n < 9600; n++) begin
         if (n > 0) step();
         if (n < 3200 && !b_hsync) hs_low++;
         if (!b_vsync) vs_low++;
         if (b_pix_en) pe_cnt++;
         if (b_bright) br_cnt++;
         if (b_r != 4'd0 || b_g != 4'd0 || b_b != 4'd0) col_cnt++;
         if (b_ft) ft_cnt++;
         if (n < 5) check("pix_en_start", b_pix_en, (n == 3));
         case (n)
            3:    check("hsync_lag", b_hsync, EXP_HS_LINE1);
            4:    check("h_first_pix", b_h, 1);
            3196: begin check("h_799", b_h, 799); check("v_line0", b_v, 0); end
            3200: begin check("h_wrap", b_h, 0); check("v_line1", b_v, 1); end
            6400: check("v_line2", b_v, 2);
            default: ;
         endcase
      end
      check("hsync_low_clks", hs_low, 384);
      check("vsync_low_clks", vs_low, 6400);
      check("pix_en_count", pe_cnt, 2400);
      check("bright_top_blank", br_cnt, 0);
      check("colour_top_blank", col_cnt, 0);
      check("no_tick_midframe", ft_cnt, 0);

      // Small geometry: frames of 16*10*4 = 640 clocks
      rst = 1'b1;
      #1;
      step(); step();
      rst = 1'b0;
      #1;
      hs_low = 0; vs_low = 0; ft_cnt = 0; ft_first = -1; ft_second = -1; vis_cnt = 0;
      for (int n = 0; n <= 1633; n++) begin
         if (n > 0) step();
         if (n < 64 && !s_hsync) hs_low++;
         if (n < 640 && !s_vsync) vs_low++;
         if (n < 640 && s_r == 4'hF) vis_cnt++;
         if (s_ft) begin
            ft_cnt++;
            if (ft_first < 0) ft_first = n;
            else if (ft_second < 0) ft_second = n;
         end
         for (int p = 0; p < 7; p++)
            if (n == 4 * PT_H[p] + 64 * PT_V[p] + 3) check($sformatf("pix_%0d_%0d", PT_H[p], PT_V[p]), s_r, EXP_PT[p]);
         case (n)
            64:  check("s_hsync_line1", s_hsync, EXP_HS_LINE1);
            215: begin check("s_vgaG_vis", s_g, 0); check("s_vgaB_vis", s_b, 0); end
            639: begin check("s_h_last", s_h, 15); check("s_v_last", s_v, 9); end
            640: begin check("s_h_wrap", s_h, 0); check("s_v_wrap", s_v, 0); end
            641: check("s_tick_one_clk", s_ft, 0);
            1633: begin check("s_mid_bright", s_bright, 1); check("s_mid_vgaR", s_r, 15); end
            default: ;
         endcase
      end
      check("s_hsync_low", hs_low, 8);
      check("s_vsync_low", vs_low, 128);
      check("s_visible_clks", vis_cnt, 200);
      check("s_tick_first", ft_first, 640);
      check("s_tick_second", ft_second, 1280);
      check("s_tick_count", ft_cnt, 2);

      // Mid-frame asynchronous reset at (8,5): outputs drop without a clock edge
      rst = 1'b1;
      #1;
      check("mr_h", s_h, 0);
      check("mr_v", s_v, 0);
      check("mr_bright", s_bright, 0);
      check("mr_vgaR", s_r, 0);
      check("mr_pix_en", s_pix_en, 0);
      check("mr_hsync", s_hsync, EXP_SYNC_RST);
      step(); step();
      rst = 1'b0;
      #1;
      for (int n = 0; n <= 64; n++) begin
         if (n > 0) step();
         case (n)
            4:  check("mr_h_first", s_h, 1);
            63: check("mr_v_hold", s_v, 0);
            64: check("mr_v_next", s_v, 1);
            default: ;
         endcase
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
